canvas_draw_scheduler: RTL and testbench

// Sequences all framebuffer writes for the drawing canvas: shares the single VGA plot port between

---
 rtl/canvas_draw_scheduler_pkg.sv | 38 +++
 rtl/canvas_draw_scheduler_rect_scanner.sv | 69 ++++++
 rtl/canvas_draw_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_canvas_draw_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_draw_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canvas_draw_scheduler_pkg
// Description : Canvas geometry defaults, colours, FSM state encodings and
//               a helper for computing a cell's pixel origin.
// Revision    : 1.0 - initial release
// ============================================================================
package canvas_draw_scheduler_pkg;

  // Canvas geometry defaults
  localparam logic [8:0]  CANVAS_X0_DEF = 9'd89;
  localparam logic [8:0]  CANVAS_Y0_DEF = 9'd33;
  localparam int          CELL_W_DEF    = 10;
  localparam int          CELL_H_DEF    = 14;
  localparam int          GRID_COLS_DEF = 14;
  localparam int          GRID_ROWS_DEF = 14;

  // Pixel colours (15-bit RGB)
  localparam logic [14:0] INK_COLOR_DEF = 15'h0000;
  localparam logic [14:0] BG_COLOR_DEF  = 15'h7FFF;

  // Scheduler FSM encodings
  localparam int          STATE_W  = 3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_STAMP = 3'd1;
  localparam logic [2:0]  ST_CLEAR = 3'd2;
  localparam logic [2:0]  ST_DROP  = 3'd3;
  localparam logic [2:0]  ST_DONE  = 3'd4;

  // Pixel origin of a cell along one axis: base + index * pitch (constant multiply)
  function automatic logic [8:0] cell_origin(input logic [8:0] base,
                                             input logic [3:0] idx,
                                             input int pitch);
    return base + (9'(idx) * 9'(pitch));
  endfunction

endpackage
`default_nettype wire

// File: rtl/canvas_draw_scheduler_rect_scanner.sv
`default_nettype none
// ============================================================================
// Module      : canvas_draw_scheduler_rect_scanner
// Description : Row-major rectangle walker. Load latches width/height and
//               resets the offsets; each enabled cycle advances dx, wrapping
//               into dy. last flags the final pixel of the rectangle.
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_draw_scheduler_rect_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [8:0] width,
  input  logic [8:0] height,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       last
);

  logic [8:0] dx_q, dx_d;
  logic [8:0] dy_q, dy_d;
  logic [8:0] w_q,  w_d;
  logic [8:0] h_q,  h_d;
  logic       end_of_row;

  assign end_of_row = (dx_q == (w_q - 9'd1));
  assign last       = end_of_row && (dy_q == (h_q - 9'd1));
  assign dx         = dx_q;
  assign dy         = dy_q;

  // Next offsets: load restarts at the corner, enable steps x fastest
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    w_d  = w_q;
    h_d  = h_q;
    if (load) begin
      dx_d = 9'd0;
      dy_d = 9'd0;
      w_d  = width;
      h_d  = height;
    end else if (en) begin
      if (end_of_row) begin
        dx_d = 9'd0;
        dy_d = dy_q + 9'd1;
      end else begin
        dx_d = dx_q + 9'd1;
      end
    end
  end

  // Offset and size registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q <= 9'd0;
      dy_q <= 9'd0;
      w_q  <= 9'd0;
      h_q  <= 9'd0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
      w_q  <= w_d;
      h_q  <= h_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/canvas_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : canvas_draw_scheduler
// Description : Arbitrates cell-stamp and canvas-clear jobs onto the single
//               framebuffer plot port, rasterising one pixel per cycle, and
//               keeps the cell occupancy bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_draw_scheduler
  import canvas_draw_scheduler_pkg::*;
#(
  parameter logic [8:0]  CANVAS_X0 = CANVAS_X0_DEF,
  parameter logic [8:0]  CANVAS_Y0 = CANVAS_Y0_DEF,
  parameter int          CELL_W    = CELL_W_DEF,
  parameter int          CELL_H    = CELL_H_DEF,
  parameter int          GRID_COLS = GRID_COLS_DEF,
  parameter int          GRID_ROWS = GRID_ROWS_DEF,
  parameter logic [14:0] INK_COLOR = INK_COLOR_DEF,
  parameter logic [14:0] BG_COLOR  = BG_COLOR_DEF
) (
  input  logic                           CLOCK_50,
  input  logic                           count_reset,
  input  logic                           stamp_req,
  input  logic [3:0]                     stamp_col,
  input  logic [3:0]                     stamp_row,
  input  logic                           stamp_ink,
  output logic                           stamp_ack,
  input  logic                           clear_req,
  output logic                           clear_ack,
  output logic                           busy,
  output logic                           done,
  output logic                           plot,
  output logic [8:0]                     x,
  output logic [8:0]                     y,
  output logic [14:0]                    color,
  output logic [GRID_ROWS*GRID_COLS-1:0] grid
);

  localparam int GRID_BITS = GRID_ROWS * GRID_COLS;
  localparam int IDX_W     = $clog2(GRID_BITS);

  logic [STATE_W-1:0]   state_q, state_d;
  logic                 stamp_ack_q, stamp_ack_d;
  logic                 clear_ack_q, clear_ack_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 plot_q, plot_d;
  logic [8:0]           x_q, x_d;
  logic [8:0]           y_q, y_d;
  logic [14:0]          color_q, color_d;
  logic [GRID_BITS-1:0] grid_q, grid_d;
  logic [8:0]           base_x_q, base_x_d;
  logic [8:0]           base_y_q, base_y_d;
  logic [14:0]          pix_color_q, pix_color_d;
  logic [3:0]           col_q, col_d;
  logic [3:0]           row_q, row_d;
  logic                 ink_q, ink_d;

  logic                 scan_load;
  logic                 scan_en;
  logic [8:0]           scan_w;
  logic [8:0]           scan_h;
  logic [8:0]           scan_dx;
  logic [8:0]           scan_dy;
  logic                 scan_last;
  logic                 stamp_in_range;
  logic [IDX_W-1:0]     cell_idx;

  assign stamp_in_range = (int'(stamp_col) < GRID_COLS) && (int'(stamp_row) < GRID_ROWS);
  assign cell_idx       = (IDX_W'(row_q) * IDX_W'(GRID_COLS)) + IDX_W'(col_q);

  canvas_draw_scheduler_rect_scanner u_rect_scanner (
    .clk    (CLOCK_50),
    .rst    (count_reset),
    .load   (scan_load),
    .en     (scan_en),
    .width  (scan_w),
    .height (scan_h),
    .dx     (scan_dx),
    .dy     (scan_dy),
    .last   (scan_last)
  );

  // State and registered outputs; reset aborts any job in flight
  always_ff @(posedge CLOCK_50) begin
    if (count_reset) begin
      state_q     <= ST_IDLE;
      stamp_ack_q <= 1'b0;
      clear_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      x_q         <= 9'd0;
      y_q         <= 9'd0;
      color_q     <= BG_COLOR;
      grid_q      <= '0;
      base_x_q    <= 9'd0;
      base_y_q    <= 9'd0;
      pix_color_q <= BG_COLOR;
      col_q       <= 4'd0;
      row_q       <= 4'd0;
      ink_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stamp_ack_q <= stamp_ack_d;
      clear_ack_q <= clear_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      plot_q      <= plot_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      grid_q      <= grid_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      pix_color_q <= pix_color_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ink_q       <= ink_d;
    end
  end

  // Next state: clear wins over stamp; out-of-grid stamps are acked then dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (stamp_req) begin
          state_d = stamp_in_range ? ST_STAMP : ST_DROP;
        end
      end
      ST_STAMP, ST_CLEAR: begin
        if (scan_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DROP: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: accept/latch in IDLE, one registered pixel per cycle while scanning
  always_comb begin
    stamp_ack_d = 1'b0;
    clear_ack_d = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    grid_d      = grid_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    pix_color_d = pix_color_q;
    col_d       = col_q;
    row_d       = row_q;
    ink_d       = ink_q;
    scan_load   = 1'b0;
    scan_en     = 1'b0;
    scan_w      = 9'd0;
    scan_h      = 9'd0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          clear_ack_d = 1'b1;
          busy_d      = 1'b1;
          base_x_d    = CANVAS_X0;
          base_y_d    = CANVAS_Y0;
          pix_color_d = BG_COLOR;
          scan_load   = 1'b1;
          scan_w      = 9'(GRID_COLS * CELL_W);
          scan_h      = 9'(GRID_ROWS * CELL_H);
        end else if (stamp_req) begin
          stamp_ack_d = 1'b1;
          busy_d      = 1'b1;
          col_d       = stamp_col;
          row_d       = stamp_row;
          ink_d       = stamp_ink;
          base_x_d    = cell_origin(CANVAS_X0, stamp_col, CELL_W);
          base_y_d    = cell_origin(CANVAS_Y0, stamp_row, CELL_H);
          pix_color_d = stamp_ink ? INK_COLOR : BG_COLOR;
          scan_load   = 1'b1;
          scan_w      = 9'(CELL_W);
          scan_h      = 9'(CELL_H);
        end
      end
      ST_STAMP, ST_CLEAR: begin
        plot_d  = 1'b1;
        x_d     = base_x_q + scan_dx;
        y_d     = base_y_q + scan_dy;
        color_d = pix_color_q;
        scan_en = 1'b1;
        if (scan_last) begin
          if (state_q == ST_CLEAR) begin
            grid_d = '0;
          end else begin
            grid_d[cell_idx] = ink_q;
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign stamp_ack = stamp_ack_q;
  assign clear_ack = clear_ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign grid      = grid_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_canvas_draw_scheduler
// Description : Scoreboard bench for canvas_draw_scheduler. Stimulus pushes
//               the expected pixel stream; a negedge monitor pops and
//               compares every plotted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_draw_scheduler;

  typedef struct packed {
    logic [8:0]  px;
    logic [8:0]  py;
    logic [14:0] pc;
  } pix_t;

  logic         clk = 1'b0;
  logic         count_reset;
  logic         stamp_req;
  logic [3:0]   stamp_col;
  logic [3:0]   stamp_row;
  logic         stamp_ink;
  logic         stamp_ack;
  logic         clear_req;
  logic         clear_ack;
  logic         busy;
  logic         done;
  logic         plot;
  logic [8:0]   x;
  logic [8:0]   y;
  logic [14:0]  color;
  logic [195:0] grid;

  int           checks = 0;
  int           errors = 0;
  int           plots_seen = 0;
  pix_t         exp_q[$];
  logic [195:0] exp_grid = '0;

  always #5 clk = ~clk;

  canvas_draw_scheduler dut (
    .CLOCK_50    (clk),
    .count_reset (count_reset),
    .stamp_req   (stamp_req),
    .stamp_col   (stamp_col),
    .stamp_row   (stamp_row),
    .stamp_ink   (stamp_ink),
    .stamp_ack   (stamp_ack),
    .clear_req   (clear_req),
    .clear_ack   (clear_ack),
    .busy        (busy),
    .done        (done),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .color       (color),
    .grid        (grid)
  );

  // Pixel monitor: every plot must match the head of the expected stream
  always @(negedge clk) begin
    pix_t e;
    if (plot === 1'b1) begin
      plots_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d color=%0h, required no plot", x, y, color);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, color} !== e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d color=%0h, required x=%0d y=%0d color=%0h",
                   x, y, color, e.px, e.py, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input logic [14:0] c);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        exp_q.push_back('{px: 9'(x0 + i), py: 9'(y0 + j), pc: c});
      end
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", {255'b0, done}, 256'd1);
  endtask

  // One stamp job with hand-computed origin and grid bit
  task automatic do_stamp(input string name, input logic [3:0] col, input logic [3:0] row,
                          input logic ink, input int x0, input int y0, input int idx,
                          input logic in_range);
    int n;
    if (in_range) push_rect(x0, y0, 10, 14, ink ? 15'h0000 : 15'h7FFF);
    stamp_col = col;
    stamp_row = row;
    stamp_ink = ink;
    stamp_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (stamp_ack !== 1'b1 && n < 40000);
    chk({name, "_ack"}, {255'b0, stamp_ack}, 256'd1);
    stamp_req = 1'b0;
    chk({name, "_noplot_in_ack_cycle"}, {255'b0, plot}, 256'd0);
    chk({name, "_no_clear_ack"}, {255'b0, clear_ack}, 256'd0);
    chk({name, "_busy"}, {255'b0, busy}, 256'd1);
    tick();
    chk({name, "_ack_one_cycle"}, {255'b0, stamp_ack}, 256'd0);
    chk({name, "_first_plot"}, {255'b0, plot}, {255'b0, in_range});
    if (in_range) begin
      wait_done(400, n);
      chk({name, "_length"}, 256'(n), 256'd140);
      exp_grid[idx] = ink;
    end else begin
      tick();
      chk({name, "_drop_done"}, {255'b0, done}, 256'd1);
    end
    chk({name, "_grid"}, {60'b0, grid}, {60'b0, exp_grid});
    chk({name, "_busy_low"}, {255'b0, busy}, 256'd0);
    chk({name, "_queue_empty"}, 256'(exp_q.size()), 256'd0);
    tick();
    chk({name, "_done_one_cycle"}, {255'b0, done}, 256'd0);
  endtask

  // Clear job with a stamp that is held pending (raised with clear, or delay cycles into it)
  task automatic clear_pend(input string name, input int delay, input logic [3:0] col,
                            input logic [3:0] row, input logic ink, input int x0,
                            input int y0, input int idx);
    int   n;
    logic seen_done;
    push_rect(89, 33, 140, 196, 15'h7FFF);
    push_rect(x0, y0, 10, 14, ink ? 15'h0000 : 15'h7FFF);
    stamp_col = col;
    stamp_row = row;
    stamp_ink = ink;
    clear_req = 1'b1;
    if (delay == 0) stamp_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (clear_ack !== 1'b1 && n < 10);
    chk({name, "_clear_ack"}, {255'b0, clear_ack}, 256'd1);
    chk({name, "_no_stamp_ack"}, {255'b0, stamp_ack}, 256'd0);
    clear_req = 1'b0;
    tick();
    chk({name, "_clear_ack_one_cycle"}, {255'b0, clear_ack}, 256'd0);
    if (delay > 0) begin
      repeat (delay) tick();
      stamp_req = 1'b1;
    end
    seen_done = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk({name, "_grid_cleared"}, {60'b0, grid}, 256'd0);
      end
    end while (stamp_ack !== 1'b1 && n < 40000);
    chk({name, "_stamp_ack"}, {255'b0, stamp_ack}, 256'd1);
    chk({name, "_stamp_after_clear_done"}, {255'b0, seen_done}, 256'd1);
    stamp_req = 1'b0;
    exp_grid = '0;
    tick();
    wait_done(400, n);
    exp_grid[idx] = ink;
    chk({name, "_grid"}, {60'b0, grid}, {60'b0, exp_grid});
    chk({name, "_queue_empty"}, 256'(exp_q.size()), 256'd0);
    tick();
  endtask

  initial begin
    int n;
    int base;
    count_reset = 1'b1;
    stamp_req   = 1'b0;
    stamp_col   = 4'd0;
    stamp_row   = 4'd0;
    stamp_ink   = 1'b0;
    clear_req   = 1'b0;
    repeat (3) tick();
    chk("rst_plot", {255'b0, plot}, 256'd0);
    chk("rst_xy", {238'b0, x, y}, 256'd0);
    chk("rst_color", {241'b0, color}, 256'h7FFF);
    chk("rst_grid", {60'b0, grid}, 256'd0);
    chk("rst_flags", {252'b0, stamp_ack, clear_ack, busy, done}, 256'd0);
    count_reset = 1'b0;
    tick();

    do_stamp("stamp00", 4'd0, 4'd0, 1'b1, 89, 33, 0, 1'b1);
    do_stamp("stamp1313_ink", 4'd13, 4'd13, 1'b1, 219, 215, 195, 1'b1);
    do_stamp("stamp1313_erase", 4'd13, 4'd13, 1'b0, 219, 215, 195, 1'b1);

    clear_pend("simul", 0, 4'd5, 4'd3, 1'b1, 139, 75, 47);

    do_stamp("drop_col14", 4'd14, 4'd2, 1'b1, 0, 0, 0, 1'b0);

    clear_pend("held_during_clear", 100, 4'd1, 4'd1, 1'b1, 99, 47, 15);

    // Reset in the middle of a stamp
    push_rect(109, 33, 10, 14, 15'h0000);
    stamp_col = 4'd2;
    stamp_row = 4'd0;
    stamp_ink = 1'b1;
    stamp_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (stamp_ack !== 1'b1 && n < 10);
    chk("midrst_ack", {255'b0, stamp_ack}, 256'd1);
    stamp_req = 1'b0;
    base = plots_seen;
    n = 0;
    while (plots_seen < base + 50 && n < 300) begin
      tick();
      n++;
    end
    chk("midrst_reached_pixel50", 256'(plots_seen - base), 256'd50);
    count_reset = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_plot", {255'b0, plot}, 256'd0);
    chk("midrst_busy", {255'b0, busy}, 256'd0);
    chk("midrst_grid", {60'b0, grid}, 256'd0);
    chk("midrst_done", {255'b0, done}, 256'd0);
    exp_grid = '0;
    count_reset = 1'b0;
    tick();
    chk("postrst_plot", {255'b0, plot}, 256'd0);
    do_stamp("after_reset", 4'd4, 4'd5, 1'b1, 129, 103, 74, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
